// File: rtl/seq_checker.sv
// Receive-side checker for a modulo-2^WIDTH incrementing stream.
// Locks after LOCK_LEN in-sequence samples and logs every break.
module seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [WIDTH-1:0] err_data,
  output logic [WIDTH-1:0] err_exp,
  output logic [CNT_W-1:0] last_err_cycle
);

  localparam int RW = $clog2(LOCK_LEN + 1);
  localparam logic [RW-1:0] LOCK_RUN = RW'(LOCK_LEN);
  localparam logic [RW-1:0] RUN_ONE = RW'(1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] nxt;
  logic [RW-1:0]    run;
  logic [CNT_W-1:0] cyc;
  logic             match;

  assign match = (din == nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      nxt            <= '0;
      run            <= '0;
      cyc            <= '0;
      locked         <= 1'b0;
      err_pulse      <= 1'b0;
      err_cnt        <= '0;
      sample_cnt     <= '0;
      err_data       <= '0;
      err_exp        <= '0;
      last_err_cycle <= '0;
    end else begin
      cyc       <= cyc + 1'b1;
      err_pulse <= 1'b0;
      if (en) begin
        if (sample_cnt != CMAX)
          sample_cnt <= sample_cnt + 1'b1;
        // always resync to the received word, match or not
        nxt <= din + 1'b1;
        unique case (state)
          IDLE: begin
            run   <= RUN_ONE;
            state <= ACQUIRE;
          end
          ACQUIRE: begin
            if (match) begin
              run <= run + 1'b1;
              if ((run + 1'b1) == LOCK_RUN) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              run <= RUN_ONE;
            end
          end
          LOCKED: begin
            if (!match) begin
              err_pulse      <= 1'b1;
              err_data       <= din;
              err_exp        <= nxt;
              last_err_cycle <= cyc;
              locked         <= 1'b0;
              run            <= RUN_ONE;
              state          <= ACQUIRE;
              if (err_cnt != CMAX)
                err_cnt <= err_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
